counter_updown_param: RTL and testbench

//   Parametrised up/down modulo counter with prescaler, synchronous clear/load,

---
 rtl/counter_updown_param.sv | 50 +++++
 tb/tb_counter_updown_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/counter_updown_param.sv
// counter_updown_param: prescaled up/down modulo counter with clear/load, optional saturation and step/terminal-count pulses
module counter_updown_param #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter int SATURATE  = 0,
    parameter int PRESCALE  = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_step
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
    logic [PW-1:0] pre;
    logic step, lim;
    logic [WIDTH-1:0] nxt, ld;
    always_comb begin
        step = i_en && pre == PLAST;
        lim  = i_dir ? o_count == MAXV : o_count == '0;
        nxt  = lim ? ((SATURATE != 0) ? o_count : (i_dir ? '0 : MAXV))
                   : (i_dir ? o_count + 1'b1 : o_count - 1'b1);
        ld   = i_load_val > MAXV ? MAXV : i_load_val;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
            pre     <= '0;
            o_tc    <= 1'b0;
            o_step  <= 1'b0;
        end else if (i_clear || i_load) begin
            o_count <= i_clear ? '0 : ld;
            pre     <= '0;
            o_tc    <= 1'b0;
            o_step  <= 1'b0;
        end else begin
            o_step <= step;
            o_tc   <= step && lim;
            if (i_en) pre <= step ? '0 : pre + 1'b1;
            if (step) o_count <= nxt;
        end
    end
endmodule

// File: tb/tb_counter_updown_param.sv
// tb_counter_updown_param: five parameter variants driven with shared stimulus and checked against an arithmetic model
module tb_counter_updown_param;
    logic clk = 1'b0, rst = 1'b1;
    logic en = 1'b0, dir = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [7:0] lv = '0;
    logic [7:0] c0, c1, c2, c3;
    logic [3:0] c4;
    logic t0, t1, t2, t3, t4, s0, s1, s2, s3, s4;
    int errors = 0, checks = 0;
    int m_max [5] = '{255, 9, 255, 255, 9};
    int m_sat [5] = '{0, 0, 1, 0, 1};
    int m_pre [5] = '{1, 1, 1, 4, 3};
    int m_lvm [5] = '{255, 255, 255, 255, 15};
    int m_cnt [5], m_pc [5], m_tc [5], m_st [5];

    always #5 clk = ~clk;

    counter_updown_param u0 (.i_clk(clk), .i_reset(rst), .i_en(en), .i_dir(dir), .i_clear(clr),
        .i_load(ld), .i_load_val(lv), .o_count(c0), .o_tc(t0), .o_step(s0));
    counter_updown_param #(.MAX_COUNT(9)) u1 (.i_clk(clk), .i_reset(rst), .i_en(en), .i_dir(dir),
        .i_clear(clr), .i_load(ld), .i_load_val(lv), .o_count(c1), .o_tc(t1), .o_step(s1));
    counter_updown_param #(.SATURATE(1)) u2 (.i_clk(clk), .i_reset(rst), .i_en(en), .i_dir(dir),
        .i_clear(clr), .i_load(ld), .i_load_val(lv), .o_count(c2), .o_tc(t2), .o_step(s2));
    counter_updown_param #(.PRESCALE(4)) u3 (.i_clk(clk), .i_reset(rst), .i_en(en), .i_dir(dir),
        .i_clear(clr), .i_load(ld), .i_load_val(lv), .o_count(c3), .o_tc(t3), .o_step(s3));
    counter_updown_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1), .PRESCALE(3)) u4 (.i_clk(clk),
        .i_reset(rst), .i_en(en), .i_dir(dir), .i_clear(clr), .i_load(ld), .i_load_val(lv[3:0]),
        .o_count(c4), .o_tc(t4), .o_step(s4));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 5; k++) begin
            m_cnt[k] = 0; m_pc[k] = 0; m_tc[k] = 0; m_st[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 5; k++) begin
            if (clr || ld) begin
                m_cnt[k] = clr ? 0 : ((int'(lv) & m_lvm[k]) > m_max[k] ? m_max[k] : (int'(lv) & m_lvm[k]));
                m_pc[k] = 0; m_tc[k] = 0; m_st[k] = 0;
            end else begin
                m_st[k] = int'(en && m_pc[k] + 1 == m_pre[k]);
                m_tc[k] = 0;
                if (en) m_pc[k] = m_st[k] != 0 ? 0 : m_pc[k] + 1;
                if (m_st[k] != 0) begin
                    m_tc[k] = int'(dir ? m_cnt[k] == m_max[k] : m_cnt[k] == 0);
                    if (!(m_tc[k] != 0 && m_sat[k] != 0))
                        m_cnt[k] = dir ? (m_cnt[k] + 1) % (m_max[k] + 1)
                                       : (m_cnt[k] + m_max[k]) % (m_max[k] + 1);
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input int c, input int t, input int s);
        check($sformatf("count%0d", k), c, m_cnt[k]);
        check($sformatf("tc%0d", k), t, m_tc[k]);
        check($sformatf("step%0d", k), s, m_st[k]);
    endtask

    task automatic check_all();
        check_inst(0, c0, t0, s0);
        check_inst(1, c1, t1, s1);
        check_inst(2, c2, t2, s2);
        check_inst(3, c3, t3, s3);
        check_inst(4, c4, t4, s4);
    endtask

    task automatic apply(input logic a_clr, input logic a_ld, input logic [7:0] a_lv,
                         input logic a_en, input logic a_dir);
        clr = a_clr; ld = a_ld; lv = a_lv; en = a_en; dir = a_dir;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int tcs, tc_at, steps;
        int en_pat [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
        reset_model();
        #2 check_all();
        do_reset();
        // wrap of the default 8-bit counter
        tcs = 0; tc_at = -1;
        for (int i = 1; i <= 260; i++) begin
            apply(0, 0, 0, 1, 1);
            if (t0) begin tcs++; tc_at = i; end
        end
        check("t1_tc_pulses", tcs, 1);
        check("t1_tc_cycle", tc_at, 256);
        check("t1_final", c0, 4);
        // mod-10 counting down from reset
        do_reset();
        apply(0, 0, 0, 1, 0); check("t2_c_a", c1, 9); check("t2_tc_a", t1, 1);
        apply(0, 0, 0, 1, 0); check("t2_c_b", c1, 8); check("t2_tc_b", t1, 0);
        apply(0, 0, 0, 1, 0); check("t2_c_c", c1, 7);
        // saturation at the top
        apply(0, 1, 8'hFE, 1, 1); check("t3_load", c2, 254);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 1, 1);
            check("t3_c", c2, 255); check("t3_tc", t2, i > 0); check("t3_step", s2, 1);
        end
        // prescale by 4 with an idle cycle
        do_reset();
        steps = 0;
        foreach (en_pat[i]) begin
            apply(0, 0, 0, en_pat[i][0], 1);
            steps += s3;
        end
        check("t4_steps", steps, 2);
        check("t4_count", c3, 2);
        // clear beats load, then load clamps
        apply(1, 1, 8'd200, 1, 1); check("t5_clr0", c0, 0); check("t5_clr1", c1, 0);
        apply(0, 1, 8'd200, 1, 1); check("t5_ld1", c1, 9); check("t5_ld0", c0, 200);
        // asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 37; i++) apply(0, 0, 0, 1, 1);
        check("t6_pre", c0, 37);
        #2 rst = 1'b1;
        #1 check("t6_async_c", c0, 0); check("t6_async_tc", t0, 0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 0, 1, 1); check("t6_resume", c0, 1);
        // random traffic
        for (int i = 0; i < 600; i++)
            apply($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
